// File: rtl/fx_chorus_mc.sv
// Multi-channel triangle-LFO chorus: per-channel circular delay line, swept tap, dry/wet mix.
// Define FX_CHORUS_INTERP_EN for a fractional delay with two-tap linear interpolation.
`timescale 1ns/1ps
module fx_chorus_mc #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned PARAM_W    = 8,
  parameter int unsigned NCH        = 2,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned BASE_DELAY = 256,
  parameter int unsigned MOD_BITS   = 8,
  parameter int unsigned PHASE_W    = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NCH-1:0][DATA_W-1:0]     audio_in,
  output logic [NCH-1:0][DATA_W-1:0]     audio_out,
  input  logic [PARAM_W-1:0]             fx_rate,
  input  logic [PARAM_W-1:0]             fx_depth,
  input  logic [PARAM_W-1:0]             fx_mix,
  input  logic                           sample_en,
  output logic                           out_valid,
  output logic                           overrun
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PROD_W    = 8 + PARAM_W;
  localparam int unsigned MOD_SHIFT = 16 - MOD_BITS;
  localparam int unsigned MIX_W     = DATA_W + PARAM_W + 2;
  localparam int unsigned PH_STEP   = (2 ** PHASE_W) / NCH;
  localparam logic signed [MIX_W-1:0] SAT_MAX = MIX_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [MIX_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DATA2,
    ST_MIX
  } state_t;

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [NCH-1:0][DATA_W-1:0] dry_q, mixed_q, out_next;
  logic [PARAM_W-1:0]         rate_q, depth_q, mix_q;
  logic [ADDR_W-1:0]          wptr_q, fill_q, raddr, d_c;
  logic [PHASE_W-1:0]         phase_q, ph;
  logic [PHASE_W-2:0]         tri_v;
  logic [7:0]                 lfo_tri8;
  logic [PROD_W-1:0]          prod;
  logic [DATA_W-1:0]          rd_q, wet_q, wet_d, mix_res;
  logic [PARAM_W:0]           coef_dry;
  logic signed [MIX_W-1:0]    dry_x, wet_x, mix_acc, mix_sh;
  logic                       capture, ram_re, wet_ld, mix_ld, commit;
  logic [DATA_W-1:0]          mem [NCH][DEPTH];

`ifdef FX_CHORUS_INTERP_EN
  logic [PROD_W+7:0]          mod_fx;
  logic [7:0]                 frac;
  logic [DATA_W-1:0]          tap_a_q;
  logic                       tap_ld;
  logic signed [DATA_W:0]     tap_diff;
  logic signed [DATA_W+9:0]   interp_prod;
`endif

  // Per-channel LFO: phase offset by 1/NCH, folded to a triangle, scaled by depth.
  always_comb begin
    ph       = phase_q + PHASE_W'(PH_STEP * ch_q);
    tri_v    = ph[PHASE_W-1] ? ~ph[PHASE_W-2:0] : ph[PHASE_W-2:0];
    lfo_tri8 = 8'(tri_v >> (PHASE_W - 9));
    prod     = PROD_W'(lfo_tri8) * PROD_W'(depth_q);
`ifdef FX_CHORUS_INTERP_EN
    mod_fx   = (PROD_W + 8)'({prod, 8'b0}) >> MOD_SHIFT;
    frac     = mod_fx[7:0];
    d_c      = ADDR_W'(BASE_DELAY) + ADDR_W'(mod_fx >> 8);
`else
    d_c      = ADDR_W'(BASE_DELAY) + ADDR_W'(prod >> MOD_SHIFT);
`endif
  end

  // Wet tap; taps older than the written history read as silence.
`ifdef FX_CHORUS_INTERP_EN
  always_comb begin
    tap_diff    = (DATA_W + 1)'($signed(rd_q)) - (DATA_W + 1)'($signed(tap_a_q));
    interp_prod = (DATA_W + 10)'(tap_diff) * (DATA_W + 10)'($signed({1'b0, frac}));
    if ((d_c + ADDR_W'(1)) > fill_q) begin
      wet_d = '0;
    end else begin
      wet_d = DATA_W'((DATA_W + 10)'($signed(tap_a_q)) + (interp_prod >>> 8));
    end
  end
`else
  always_comb begin
    wet_d = (d_c > fill_q) ? '0 : rd_q;
  end
`endif

  // Dry/wet crossfade with floor shift and clamp.
  always_comb begin
    dry_x    = MIX_W'($signed(dry_q[ch_q]));
    wet_x    = MIX_W'($signed(wet_q));
    coef_dry = (PARAM_W + 1)'(2 ** PARAM_W) - (PARAM_W + 1)'(mix_q);
    mix_acc  = dry_x * $signed(MIX_W'(coef_dry)) + wet_x * $signed(MIX_W'(mix_q));
    mix_sh   = mix_acc >>> PARAM_W;
    if (mix_sh > SAT_MAX) begin
      mix_res = DATA_W'(SAT_MAX);
    end else if (mix_sh < SAT_MIN) begin
      mix_res = DATA_W'(SAT_MIN);
    end else begin
      mix_res = DATA_W'(mix_sh);
    end
    out_next         = mixed_q;
    out_next[ch_q]   = mix_res;
  end

  // Sequencer: one channel at a time, commit folded into the last MIX cycle.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    capture = 1'b0;
    ram_re  = 1'b0;
    raddr   = wptr_q - d_c;
    wet_ld  = 1'b0;
    mix_ld  = 1'b0;
    commit  = 1'b0;
`ifdef FX_CHORUS_INTERP_EN
    tap_ld  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sample_en) begin
          capture = 1'b1;
          ch_d    = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ram_re  = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
`ifdef FX_CHORUS_INTERP_EN
        ram_re  = 1'b1;
        raddr   = wptr_q - d_c - ADDR_W'(1);
        tap_ld  = 1'b1;
        state_d = ST_DATA2;
`else
        wet_ld  = 1'b1;
        state_d = ST_MIX;
`endif
      end
`ifdef FX_CHORUS_INTERP_EN
      ST_DATA2: begin
        wet_ld  = 1'b1;
        state_d = ST_MIX;
      end
`endif
      ST_MIX: begin
        mix_ld = 1'b1;
        if (ch_q == CH_W'(NCH - 1)) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dry_q     <= '0;
      rate_q    <= '0;
      depth_q   <= '0;
      mix_q     <= '0;
      wet_q     <= '0;
      mixed_q   <= '0;
      wptr_q    <= '0;
      fill_q    <= '0;
      phase_q   <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef FX_CHORUS_INTERP_EN
      tap_a_q   <= '0;
`endif
    end else begin
      out_valid <= commit;
      if (sample_en && (state_q != ST_IDLE)) overrun <= 1'b1;
      if (capture) begin
        dry_q   <= audio_in;
        rate_q  <= fx_rate;
        depth_q <= fx_depth;
        mix_q   <= fx_mix;
      end
`ifdef FX_CHORUS_INTERP_EN
      if (tap_ld) tap_a_q <= rd_q;
`endif
      if (wet_ld) wet_q <= wet_d;
      if (mix_ld) mixed_q[ch_q] <= mix_res;
      if (commit) begin
        audio_out <= out_next;
        wptr_q    <= wptr_q + ADDR_W'(1);
        fill_q    <= (fill_q == ADDR_W'(DEPTH - 1)) ? fill_q : fill_q + ADDR_W'(1);
        phase_q   <= phase_q + PHASE_W'(rate_q) + PHASE_W'(1);
      end
    end
  end

  // Delay RAM: synchronous read, all channels written together on commit; no reset.
  always_ff @(posedge clk) begin
    if (commit && reset_n) begin
      for (int c = 0; c < NCH; c++) mem[c][wptr_q] <= dry_q[c];
    end
    if (ram_re) rd_q <= mem[ch_q][raddr];
  end

endmodule

// File: tb/tb_fx_chorus_mc.sv
// Directed bench for fx_chorus_mc with hand-derived expected samples.
`timescale 1ns/1ps
module tb_fx_chorus_mc;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned PARAM_W = 8;
  localparam int unsigned NCH     = 2;
`ifdef FX_CHORUS_INTERP_EN
  localparam int LAT = 4 * NCH + 1;
`else
  localparam int LAT = 3 * NCH + 1;
`endif

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic [NCH-1:0][DATA_W-1:0] audio_in;
  logic [NCH-1:0][DATA_W-1:0] audio_out;
  logic [PARAM_W-1:0]         fx_rate, fx_depth, fx_mix;
  logic                       sample_en;
  logic                       out_valid;
  logic                       overrun;

  int errors = 0;
  int checks = 0;

  fx_chorus_mc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .audio_in  (audio_in),
    .audio_out (audio_out),
    .fx_rate   (fx_rate),
    .fx_depth  (fx_depth),
    .fx_mix    (fx_mix),
    .sample_en (sample_en),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (3) begin
      sample_en = 1'($urandom_range(0, 1));
      audio_in  = {16'($urandom), 16'($urandom)};
      fx_rate   = 8'($urandom);
      fx_depth  = 8'($urandom);
      fx_mix    = 8'($urandom);
      @(posedge clk); #1;
    end
    reset_n   = 1'b1;
    sample_en = 1'b0;
    audio_in  = '0;
  endtask

  // One strobe in cycle 0; returns the cycle out_valid was seen and the outputs then.
  task automatic run_sample(input logic [15:0] a0, input logic [15:0] a1,
                            output logic [15:0] o0, output logic [15:0] o1, output int lat);
    @(posedge clk); #1;
    audio_in[0] = a0;
    audio_in[1] = a1;
    sample_en   = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) check("out_valid timeout", 32'(lat), 32'(LAT));
    o0 = audio_out[0];
    o1 = audio_out[1];
  endtask

  function automatic logic [15:0] mix255(input int dry, input int wet);
    int acc;
    acc = dry + wet * 255;
    return 16'(acc >>> 8);
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] o0, o1;
    int lat, nvalid, first, v0, v1, w0, w1;
    int h0[1100];
    int h1[1100];

    reset_n   = 1'b0;
    sample_en = 1'b0;
    audio_in  = '0;
    fx_rate   = '0;
    fx_depth  = '0;
    fx_mix    = '0;

    // Reset with garbage inputs
    do_reset();
    check("t1 audio_out", 32'(audio_out), 32'h0);
    check("t1 out_valid", 32'(out_valid), 32'h0);
    check("t1 overrun",   32'(overrun),   32'h0);

    // Reset mid-operation aborts the sample
    fx_mix = 8'd0;
    @(posedge clk); #1;
    audio_in[0] = 16'h7777;
    audio_in[1] = 16'h5555;
    sample_en   = 1'b1;
    nvalid = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (out_valid) nvalid++;
      sample_en = 1'b0;
      reset_n   = (k == 3) ? 1'b0 : 1'b1;
    end
    check("t1b out_valid count", 32'(nvalid), 32'd0);
    check("t1b audio_out",       32'(audio_out), 32'h0);

    // Fully dry passes input through exactly
    do_reset();
    fx_mix = 8'd0; fx_depth = 8'd99; fx_rate = 8'd3;
    run_sample(16'h1234, 16'h8001, o0, o1, lat);
    check("t2 latency", 32'(lat), 32'(LAT));
    check("t2 ch0", 32'(o0), 32'h1234);
    check("t2 ch1", 32'(o1), 32'h8001);
    @(posedge clk); #1;
    check("t2 out_valid pulse", 32'(out_valid), 32'h0);
    check("t2 hold ch0", 32'(audio_out[0]), 32'h1234);

    // Overrun: second strobe in cycle 3 ignored
    do_reset();
    fx_mix = 8'd0; fx_depth = 8'd0; fx_rate = 8'd0;
    @(posedge clk); #1;
    audio_in[0] = 16'h1111;
    audio_in[1] = 16'h2222;
    sample_en   = 1'b1;
    nvalid = 0;
    first  = 0;
    o0 = '0;
    o1 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        nvalid++;
        if (first == 0) begin
          first = k;
          o0 = audio_out[0];
          o1 = audio_out[1];
        end
      end
      if (k == 3) check("t5 overrun before", 32'(overrun), 32'h0);
      if (k == 4) check("t5 overrun set",    32'(overrun), 32'h1);
      sample_en = (k == 3);
      if (k == 3) begin
        audio_in[0] = 16'h3333;
        audio_in[1] = 16'h4444;
      end
    end
    check("t5 valid count", 32'(nvalid), 32'd1);
    check("t5 valid cycle", 32'(first), 32'(LAT));
    check("t5 ch0", 32'(o0), 32'h1111);
    check("t5 ch1", 32'(o1), 32'h2222);
    run_sample(16'h3333, 16'h4444, o0, o1, lat);
    check("t5 next ch0", 32'(o0), 32'h3333);
    check("t5 overrun sticky", 32'(overrun), 32'h1);

    // Full-depth sweep: sample 640 has phase 0x8000 (ch0 d=510, ch1 d=256)
    do_reset();
    fx_mix = 8'd255; fx_depth = 8'd255; fx_rate = 8'd255;
    for (int n = 0; n <= 641; n++) begin
      run_sample((n == 130) ? 16'h4000 : 16'h0000, (n == 384) ? 16'h4000 : 16'h0000, o0, o1, lat);
      if (n == 639) begin
        check("t4 n639 ch0 d509", 32'(o0), 32'h3FC0);
        check("t4 n639 ch1 d256", 32'(o1), 32'h0000);
      end
      if (n == 640) begin
        check("t4 n640 ch0 d510", 32'(o0), 32'h3FC0);
        check("t4 n640 ch1 d256", 32'(o1), 32'h3FC0);
      end
      if (n == 641) begin
        check("t4 n641 ch0 d508", 32'(o0), 32'h0000);
        check("t4 n641 ch1 d257", 32'(o1), 32'h3FC0);
      end
    end

    // Signed ramp through a fixed 256 delay, across the wptr wrap
    do_reset();
    fx_mix = 8'd255; fx_depth = 8'd0; fx_rate = 8'h5A;
    for (int n = 0; n < 1100; n++) begin
      v0 = -16000 + 29 * n;
      v1 = 15000 - 27 * n;
      h0[n] = v0;
      h1[n] = v1;
      run_sample(16'(v0), 16'(v1), o0, o1, lat);
      w0 = (n >= 256) ? h0[n-256] : 0;
      w1 = (n >= 256) ? h1[n-256] : 0;
      check($sformatf("t6 ch0 n=%0d", n), 32'(o0), 32'(mix255(v0, w0)));
      check($sformatf("t6 ch1 n=%0d", n), 32'(o1), 32'(mix255(v1, w1)));
    end

    // Impulse through fixed delay; stale RAM must read as silence until filled
    do_reset();
    fx_mix = 8'd255; fx_depth = 8'd0; fx_rate = 8'd37;
    for (int n = 0; n <= 300; n++) begin
      run_sample((n == 0) ? 16'h4000 : 16'h0000, 16'h0000, o0, o1, lat);
      if (n == 0) check("t3 latency", 32'(lat), 32'(LAT));
      check($sformatf("t3 ch0 n=%0d", n), 32'(o0),
            (n == 0) ? 32'h0040 : ((n == 256) ? 32'h3FC0 : 32'h0000));
      check($sformatf("t3 ch1 n=%0d", n), 32'(o1), 32'h0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
